// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED blink array.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_ONESHOT = 2'd3
  } led_mode_t;

  localparam int PWM_W = 4;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/half/phase/state registers, advanced by the shared tick.
// Optional LED_PWM_EN adds a per-channel duty register and PWM compare.
//
// state (mode_q) | meaning
// LED_OFF        | led low, phase held at 0
// LED_ON         | led high, phase held at 0
// LED_BLINK      | led toggles every half ticks
// LED_ONESHOT    | led high for half ticks, then falls back to LED_OFF
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int PER_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr,
  input  led_mode_t        mode,
  input  logic [PER_W-1:0] half,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0] duty,
  input  logic [PWM_W-1:0] pwm_cnt,
`endif
  output logic             led
);

  led_mode_t        mode_q, mode_d;
  logic [PER_W-1:0] half_q, half_d;
  logic [PER_W-1:0] phase_q, phase_d;
  logic             state_q, state_d;
  logic             last;

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] duty_q, duty_d;
`endif

  assign last = (phase_q == half_q - PER_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= LED_OFF;
      half_q  <= PER_W'(1);
      phase_q <= '0;
      state_q <= 1'b0;
`ifdef LED_PWM_EN
      duty_q  <= '1;
`endif
    end else begin
      mode_q  <= mode_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      state_q <= state_d;
`ifdef LED_PWM_EN
      duty_q  <= duty_d;
`endif
    end
  end

  always_comb begin
    mode_d  = mode_q;
    half_d  = half_q;
    phase_d = phase_q;
    state_d = state_q;
`ifdef LED_PWM_EN
    duty_d  = duty_q;
`endif
    // A write takes priority over a coincident tick, which is dropped.
    if (wr) begin
      mode_d  = mode;
      half_d  = (half == '0) ? PER_W'(1) : half;
      phase_d = '0;
      state_d = (mode != LED_OFF);
`ifdef LED_PWM_EN
      duty_d  = duty;
`endif
    end else if (tick) begin
      case (mode_q)
        LED_BLINK: begin
          if (last) begin
            phase_d = '0;
            state_d = ~state_q;
          end else begin
            phase_d = phase_q + PER_W'(1);
          end
        end
        LED_ONESHOT: begin
          if (last) begin
            phase_d = '0;
            state_d = 1'b0;
            mode_d  = LED_OFF;
          end else begin
            phase_d = phase_q + PER_W'(1);
          end
        end
        default: phase_d = '0;
      endcase
    end
  end

`ifdef LED_PWM_EN
  assign led = state_q && (pwm_cnt <= duty_q);
`else
  assign led = state_q;
`endif

endmodule

// File: rtl/led_blink_array.sv
// Array of independent LED blinkers sharing one tick prescaler and a config port.
// Optional LED_PWM_EN adds cfg_duty and a free-running PWM counter.
module led_blink_array
  import led_ctrl_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int TICK_DIV = 48000,
  parameter  int PER_W    = 12,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  led_mode_t         cfg_mode,
  input  logic [PER_W-1:0]  cfg_half,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]  cfg_duty,
`endif
  output logic              tick,
  output logic [NUM_CH-1:0] led
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = cfg_valid && cfg_ready;
  assign tick   = (cnt == CNT_LAST);

  // Ready drops for one cycle after every accept, limiting writes to one per two cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      cfg_ready <= 1'b1;
    end else begin
      cnt       <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      cfg_ready <= ~accept;
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_W'(1);
  end
`endif

  // Out-of-range cfg_ch matches no channel, so the write is consumed silently.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(
      .PER_W (PER_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .wr      (accept && (cfg_ch == CH_W'(i))),
      .mode    (cfg_mode),
      .half    (cfg_half),
`ifdef LED_PWM_EN
      .duty    (cfg_duty),
      .pwm_cnt (pwm_cnt),
`endif
      .led     (led[i])
    );
  end

endmodule
